// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: redirect source
// encoding and width-generic target helpers.
package pc_seq_pkg;

    localparam int unsigned SRC_W = 3;

    typedef enum logic [SRC_W-1:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        JR     = 3'd3,
        RET    = 3'd4
    } redirect_src_e;

    // Region jump: keep base bits above jump_w, replace [jump_w:1] with raw, bit 0 = 0.
    // Operates on 64-bit containers so callers of any width can zero-extend in and truncate out.
    function automatic logic [63:0] region_target(input logic [63:0] base,
                                                  input logic [63:0] raw,
                                                  input int unsigned jump_w);
        logic [63:0] low_mask;
        low_mask = (64'd1 << (jump_w + 1)) - 64'd1;
        return (base & ~low_mask) | ((raw << 1) & low_mask);
    endfunction

    // Sign-extend a br_w-bit word offset and convert it to a byte offset.
    function automatic logic [63:0] sext_shl1(input logic [63:0] off,
                                              input int unsigned br_w);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << br_w) - 64'd1;
        v    = off & mask;
        if (off[br_w-1]) begin
            v = v | ~mask;
        end
        return v << 1;
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Used only when PC_SEQUENCER_RAS_EN is defined. DEPTH must be a power of two >= 2.
module return_address_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_dec;
    logic [CNT_W-1:0] count;
    logic             full;

    assign sp_dec = sp - PTR_W'(1);
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign top    = mem[sp_dec];

    // Entry storage: push+pop replaces the top in place, a plain push writes the next slot.
    always_ff @(posedge clk) begin
        if (push && pop) begin
            mem[sp_dec] <= push_data;
        end else if (push) begin
            mem[sp] <= push_data;
        end
    end

    // Pointer, occupancy and overflow pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && !pop && full;
            if (push && !pop) begin
                sp <= sp + PTR_W'(1);
                if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop && !push) begin
                sp    <= sp_dec;
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered PC with ret > jr > jump > branch > sequential priority.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          JUMP_W    = 11,
    parameter int unsigned          BR_W      = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              jump,
    input  logic [JUMP_W-1:0] jump_raw,
    input  logic              branch_taken,
    input  logic [BR_W-1:0]   branch_offset,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              link,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_two,
    output logic              redirect,
    output logic [2:0]        redirect_src,
    output logic              misalign_err,
    output logic              ras_empty,
    output logic              ras_overflow
);

    logic [ADDR_W-1:0] pc_q;
    redirect_src_e     src_q;
    logic              redirect_q;
    logic              misalign_q;

    logic [ADDR_W-1:0] next_pc;
    redirect_src_e     next_src;
    logic              next_misalign;

    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jr_aligned;

    logic              ras_is_empty;
    logic [ADDR_W-1:0] ras_top;

    assign pc_plus_two = pc_q + ADDR_W'(2);
    assign jump_tgt    = ADDR_W'(region_target(64'(pc_plus_two), 64'(jump_raw), JUMP_W));
    assign branch_tgt  = pc_plus_two + ADDR_W'(sext_shl1(64'(branch_offset), BR_W));
    assign jr_aligned  = {jr_target[ADDR_W-1:1], 1'b0};

`ifdef PC_SEQUENCER_RAS_EN
    logic ras_push;
    logic ras_pop;

    assign ras_push = link && !stall;
    assign ras_pop  = ret && !ras_is_empty && !stall;

    return_address_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_two),
        .top       (ras_top),
        .empty     (ras_is_empty),
        .overflow  (ras_overflow)
    );
`else
    logic        unused_link;
    logic [31:0] unused_depth;

    assign unused_link  = link;
    assign unused_depth = 32'(RAS_DEPTH);
    assign ras_is_empty = 1'b1;
    assign ras_top      = '0;
    assign ras_overflow = 1'b0;
`endif

    // Next-PC selection by request priority; lower requests are dropped.
    always_comb begin
        next_pc       = pc_plus_two;
        next_src      = SEQ;
        next_misalign = 1'b0;
        if (ret) begin
            next_src = RET;
            if (!ras_is_empty) begin
                next_pc = ras_top;
            end else begin
                next_pc       = jr_aligned;
                next_misalign = jr_target[0];
            end
        end else if (jr) begin
            next_pc       = jr_aligned;
            next_src      = JR;
            next_misalign = jr_target[0];
        end else if (jump) begin
            next_pc  = jump_tgt;
            next_src = JUMP;
        end else if (branch_taken) begin
            next_pc  = branch_tgt;
            next_src = BRANCH;
        end
    end

    // PC and status registers; stall holds state and suppresses pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            src_q      <= SEQ;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else if (stall) begin
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= next_pc;
            src_q      <= next_src;
            redirect_q <= (next_src != SEQ);
            misalign_q <= next_misalign;
        end
    end

    assign pc           = pc_q;
    assign redirect     = redirect_q;
    assign redirect_src = src_q;
    assign misalign_err = misalign_q;
    assign ras_empty    = ras_is_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; RAS steps are built when PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [10:0] jump_raw;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic        jr;
    logic [15:0] jr_target;
    logic        link;
    logic        ret;
    logic [15:0] pc;
    logic [15:0] pc_plus_two;
    logic        redirect;
    logic [2:0]  redirect_src;
    logic        misalign_err;
    logic        ras_empty;
    logic        ras_overflow;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .ADDR_W    (16),
        .JUMP_W    (11),
        .BR_W      (8),
        .RESET_PC  (16'h0000),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .jump          (jump),
        .jump_raw      (jump_raw),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jr            (jr),
        .jr_target     (jr_target),
        .link          (link),
        .ret           (ret),
        .pc            (pc),
        .pc_plus_two   (pc_plus_two),
        .redirect      (redirect),
        .redirect_src  (redirect_src),
        .misalign_err  (misalign_err),
        .ras_empty     (ras_empty),
        .ras_overflow  (ras_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; jump = 0; jump_raw = '0; branch_taken = 0; branch_offset = '0;
        jr = 0; jr_target = '0; link = 0; ret = 0;
    endtask

    task automatic goto(input logic [15:0] a);
        idle(); jr = 1; jr_target = a;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        step(); step();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_redirect", redirect, 0);
        chk("rst_src", redirect_src, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_ovf", ras_overflow, 0);
        chk("rst_empty", ras_empty, 1);

        rst_n = 1;
        step();
        chk("seq_pc1", pc, 16'h0002);
        chk("seq_redirect1", redirect, 0);
        step();
        chk("seq_pc2", pc, 16'h0004);

        goto(16'hFFFE);
        chk("jr_pc_top", pc, 16'hFFFE);
        chk("jr_redirect", redirect, 1);
        chk("jr_src", redirect_src, 3);
        step();
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_redirect", redirect, 0);
        chk("wrap_src", redirect_src, 0);

        goto(16'h3FFE);
        jump = 1; jump_raw = 11'h155;
        step(); idle();
        chk("jump_pc", pc, 16'h42AA);
        chk("jump_redirect", redirect, 1);
        chk("jump_src", redirect_src, 2);

        goto(16'h0100);
        branch_taken = 1; branch_offset = 8'hFE;
        step(); idle();
        chk("br_neg_pc", pc, 16'h00FE);
        chk("br_src", redirect_src, 1);
        goto(16'h0100);
        branch_taken = 1; branch_offset = 8'h7F;
        step(); idle();
        chk("br_pos_pc", pc, 16'h0200);

        jr = 1; jr_target = 16'h1235; jump = 1; jump_raw = 11'h7FF; branch_taken = 1; branch_offset = 8'h10;
        step();
        chk("prio_pc", pc, 16'h1234);
        chk("prio_src", redirect_src, 3);
        chk("prio_misalign", misalign_err, 1);
        chk("prio_pc2", pc_plus_two, 16'h1236);
        stall = 1;
        step();
        chk("stall_pc", pc, 16'h1234);
        chk("stall_redirect", redirect, 0);
        chk("stall_misalign", misalign_err, 0);
        chk("stall_src", redirect_src, 3);
        idle();
        step();
        chk("post_stall_pc", pc, 16'h1236);
        chk("post_stall_misalign", misalign_err, 0);

        ret = 1; jr = 1; jr_target = 16'h0801;
        step(); idle();
        chk("ret_fb_pc", pc, 16'h0800);
        chk("ret_fb_src", redirect_src, 4);
        chk("ret_fb_misalign", misalign_err, 1);

`ifdef PC_SEQUENCER_RAS_EN
        goto(16'h0010);
        for (int i = 0; i < 5; i++) begin
            link = 1; jr = 1; jr_target = 16'(16'h0020 + 16'(i) * 16'h0010);
            step(); idle();
            chk($sformatf("link%0d_ovf", i), ras_overflow, (i == 4) ? 1 : 0);
            chk($sformatf("link%0d_empty", i), ras_empty, 0);
        end
        ret = 1; jr_target = 16'h0700;
        step();
        chk("ret0_pc", pc, 16'h0052);
        chk("ret0_src", redirect_src, 4);
        step();
        chk("ret1_pc", pc, 16'h0042);
        step();
        chk("ret2_pc", pc, 16'h0032);
        step();
        chk("ret3_pc", pc, 16'h0022);
        chk("ret3_empty", ras_empty, 1);
        step(); idle();
        chk("ret4_fb_pc", pc, 16'h0700);
        chk("ret4_misalign", misalign_err, 0);
        link = 1;
        step(); idle();
        chk("relink_empty", ras_empty, 0);
`else
        link = 1;
        step(); idle();
        chk("link_ignored_pc", pc, 16'h0802);
        chk("link_ignored_empty", ras_empty, 1);
        chk("link_ignored_ovf", ras_overflow, 0);
`endif

        rst_n = 0; jr = 1; jr_target = 16'h4444; stall = 1;
        step();
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_empty", ras_empty, 1);
        chk("midrst_redirect", redirect, 0);
        chk("midrst_src", redirect_src, 0);
        idle(); rst_n = 1;
        step();
        chk("after_rst_pc", pc, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
